// File: rtl/fixed2_seq_ctrl.sv
// Sequencer that feeds one 8x8 element to a fixed2 (2-bit weight) PE as four
// weight slices and accumulates the shifted partial sums into a dot product.
module fixed2_seq_ctrl #(
  parameter int COL_WIDTH = 11,
  parameter int ACC_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [7:0]           in_act,
  input  logic [7:0]           in_weight,
  input  logic                 in_s_in,
  input  logic                 in_s_weight,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic [7:0]           pe_in,
  output logic [1:0]           pe_weight,
  output logic                 pe_s_in,
  output logic                 pe_s_weight,
  output logic [COL_WIDTH-1:0] pe_psum_in,
  input  logic [COL_WIDTH-1:0] pe_psum_fwd
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  state_e state_q, state_d;

  logic [1:0]           slice_q, slice_d;
  logic                 drain_q, drain_d;
  logic [7:0]           act_q, act_d, wgt_q, wgt_d;
  logic                 s_in_q, s_in_d, s_w_q, s_w_d, last_q, last_d;
  logic [7:0]           pe_in_q, pe_in_d;
  logic [1:0]           pe_weight_q, pe_weight_d;
  logic                 pe_s_in_q, pe_s_in_d, pe_s_weight_q, pe_s_weight_d;
  logic [1:0]           vld_pipe_q, vld_pipe_d;
  logic [1:0][2:0]      tag_q, tag_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;

  logic                 accept, issue, done_hs;
  logic [1:0]           k;
  logic [7:0]           act_src, w_src, w_sh;
  logic                 s_in_src, s_w_src;
  logic [ACC_WIDTH-1:0] psum_ext, psum_sh;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (in_valid) state_d = ISSUE;
      ISSUE: if (slice_q == 2'd3) state_d = DRAIN;
      DRAIN: if (drain_q) state_d = last_q ? DONE : IDLE;
      DONE:  if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    accept    = in_ready & in_valid;
    issue     = accept | (state_q == ISSUE);
    done_hs   = out_valid & out_ready;
  end

  // Slice 0 is issued straight from the inputs on the accepting edge.
  always_comb begin
    act_d    = act_q;
    wgt_d    = wgt_q;
    s_in_d   = s_in_q;
    s_w_d    = s_w_q;
    last_d   = last_q;
    act_src  = act_q;
    w_src    = wgt_q;
    s_in_src = s_in_q;
    s_w_src  = s_w_q;
    k        = slice_q;
    if (accept) begin
      act_d    = in_act;
      wgt_d    = in_weight;
      s_in_d   = in_s_in;
      s_w_d    = in_s_weight;
      last_d   = in_last;
      act_src  = in_act;
      w_src    = in_weight;
      s_in_src = in_s_in;
      s_w_src  = in_s_weight;
      k        = 2'd0;
    end
    slice_d = issue ? 2'(k + 2'd1) : 2'd0;
    drain_d = (state_q == DRAIN) ? ~drain_q : 1'b0;

    w_sh          = w_src >> {k, 1'b0};
    pe_in_d       = issue ? act_src : 8'd0;
    pe_weight_d   = issue ? w_sh[1:0] : 2'd0;
    pe_s_in_d     = issue & s_in_src;
    pe_s_weight_d = issue & (k == 2'd3) & s_w_src;

    // Tag rides two stages so it meets the PE result for the same slice.
    vld_pipe_d = {vld_pipe_q[0], issue};
    tag_d      = {tag_q[0], (issue ? {k, 1'b0} : 3'd0)};

    psum_ext = {{(ACC_WIDTH-COL_WIDTH){pe_psum_fwd[COL_WIDTH-1]}}, pe_psum_fwd};
    psum_sh  = psum_ext << tag_q[1];
    acc_d    = acc_q;
    if (done_hs)            acc_d = '0;
    else if (vld_pipe_q[1]) acc_d = acc_q + psum_sh;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slice_q       <= '0;
      drain_q       <= 1'b0;
      act_q         <= '0;
      wgt_q         <= '0;
      s_in_q        <= 1'b0;
      s_w_q         <= 1'b0;
      last_q        <= 1'b0;
      pe_in_q       <= '0;
      pe_weight_q   <= '0;
      pe_s_in_q     <= 1'b0;
      pe_s_weight_q <= 1'b0;
      vld_pipe_q    <= '0;
      tag_q         <= '0;
      acc_q         <= '0;
    end else begin
      slice_q       <= slice_d;
      drain_q       <= drain_d;
      act_q         <= act_d;
      wgt_q         <= wgt_d;
      s_in_q        <= s_in_d;
      s_w_q         <= s_w_d;
      last_q        <= last_d;
      pe_in_q       <= pe_in_d;
      pe_weight_q   <= pe_weight_d;
      pe_s_in_q     <= pe_s_in_d;
      pe_s_weight_q <= pe_s_weight_d;
      vld_pipe_q    <= vld_pipe_d;
      tag_q         <= tag_d;
      acc_q         <= acc_d;
    end
  end

  assign out_data    = acc_q;
  assign pe_in       = pe_in_q;
  assign pe_weight   = pe_weight_q;
  assign pe_s_in     = pe_s_in_q;
  assign pe_s_weight = pe_s_weight_q;
  assign pe_psum_in  = '0;

endmodule
